// File: rtl/bmi_speed_mapper.sv
// BMI calculator (weight*10000/height^2, restoring divider) and BMI-to-speed-level mapper.
// Optional build macro BMI_ROUND_EN: rounds BMI half-up instead of truncating.
module bmi_speed_mapper #(
  parameter int unsigned H_W        = 8,
  parameter int unsigned W_W        = 7,
  parameter int unsigned BMI_W      = 6,
  parameter int unsigned LVL_W      = 4,
  parameter int unsigned HEIGHT_MIN = 100,
  parameter int unsigned BMI_MIN    = 15,
  parameter int unsigned BMI_MAX    = 30,
  parameter int unsigned SPEED_MIN  = 1,
  parameter int unsigned SPEED_MAX  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [H_W-1:0]   height,
  input  logic [W_W-1:0]   weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BMI_W-1:0] bmi,
  output logic [LVL_W-1:0] speed_level,
  output logic             err
);

  localparam int unsigned NUM_W  = W_W + 14;
  localparam int unsigned SQ_W   = 2 * H_W;
  localparam int unsigned PROD_W = LVL_W + BMI_W;
  localparam int unsigned STEP_W = $clog2(NUM_W + 1);
  localparam int unsigned BMI_SAT = (1 << BMI_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SQUARE, S_DIV, S_MAP, S_DONE
  } state_t;

  state_t            state_q;
  logic [H_W-1:0]    h_q;
  logic [W_W-1:0]    w_q;
  logic [SQ_W-1:0]   div_q;
  logic [NUM_W-1:0]  num_q;
  logic [SQ_W-1:0]   rem_q;
  logic [STEP_W-1:0] step_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [BMI_W-1:0]  bmi_q;
  logic [LVL_W-1:0]  lvl_q;
  logic              err_q;

  logic [SQ_W-1:0]   sq_c;
  logic [SQ_W:0]     rem_sh_c;
  logic              sub_ok_c;
  logic [SQ_W-1:0]   rem_d;
  logic [NUM_W-1:0]  num_d;
  logic [BMI_W-1:0]  bmi_d;
  logic [PROD_W-1:0] prod_c;
  logic [LVL_W-1:0]  lvl_d;

  assign sq_c = SQ_W'(h_q) * SQ_W'(h_q);

  // One restoring-division step: numerator shifts out MSB-first, quotient bits shift in at LSB.
  always_comb begin
    rem_sh_c = {rem_q, num_q[NUM_W-1]};
    sub_ok_c = (rem_sh_c >= {1'b0, div_q});
    rem_d    = sub_ok_c ? SQ_W'(rem_sh_c - {1'b0, div_q}) : rem_sh_c[SQ_W-1:0];
    num_d    = {num_q[NUM_W-2:0], sub_ok_c};
  end

  // Saturate the quotient and map it linearly between the knee points.
  always_comb begin
    bmi_d  = (num_q > NUM_W'(BMI_SAT)) ? BMI_W'(BMI_SAT) : num_q[BMI_W-1:0];
    prod_c = '0;
    if (bmi_d <= BMI_W'(BMI_MIN)) begin
      lvl_d = LVL_W'(SPEED_MAX);
    end else if (bmi_d >= BMI_W'(BMI_MAX)) begin
      lvl_d = LVL_W'(SPEED_MIN);
    end else begin
      prod_c = PROD_W'(SPEED_MAX - SPEED_MIN) * PROD_W'(bmi_d - BMI_W'(BMI_MIN));
      lvl_d  = LVL_W'(SPEED_MAX) - LVL_W'(prod_c / PROD_W'(BMI_MAX - BMI_MIN));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      w_q         <= '0;
      div_q       <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bmi_q       <= '0;
      lvl_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            h_q        <= height;
            w_q        <= weight;
            if ((height < H_W'(HEIGHT_MIN)) || (weight == '0)) begin
              out_valid_q <= 1'b1;
              err_q       <= 1'b1;
              bmi_q       <= '0;
              lvl_q       <= '0;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_SQUARE;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_SQUARE: begin
          div_q  <= sq_c;
`ifdef BMI_ROUND_EN
          num_q  <= NUM_W'(w_q) * NUM_W'(10000) + NUM_W'(sq_c >> 1);
`else
          num_q  <= NUM_W'(w_q) * NUM_W'(10000);
`endif
          rem_q   <= '0;
          step_q  <= '0;
          state_q <= S_DIV;
        end
        S_DIV: begin
          rem_q  <= rem_d;
          num_q  <= num_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(NUM_W - 1)) state_q <= S_MAP;
        end
        S_MAP: begin
          bmi_q       <= bmi_d;
          lvl_q       <= lvl_d;
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign bmi         = bmi_q;
  assign speed_level = lvl_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bmi_speed_mapper.sv
// Self-checking bench for bmi_speed_mapper: directed cases, randomized samples against an
// arithmetic reference model, mid-computation reset and back-to-back throughput.
module tb_bmi_speed_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] height;
  logic [6:0] weight;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] bmi;
  logic [3:0] speed_level;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  bmi_speed_mapper dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .height(height), .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .bmi(bmi), .speed_level(speed_level), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: BMI and speed level straight from the arithmetic rules.
  task automatic model(input int h, input int w, output int eb, output int el, output int ee);
    int num, q;
    if (h < 100 || w == 0) begin
      ee = 1; eb = 0; el = 0;
    end else begin
      ee  = 0;
      num = w * 10000;
`ifdef BMI_ROUND_EN
      num = num + (h * h) / 2;
`endif
      q  = num / (h * h);
      eb = (q > 63) ? 63 : q;
      if (eb <= 15)      el = 10;
      else if (eb >= 30) el = 1;
      else               el = 10 - (9 * (eb - 15)) / 15;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, check latency and result, hold out_ready low for 'hold' cycles, then consume.
  task automatic run_sample(input int h, input int w, input int eb, input int el,
                            input int ee, input int hold);
    int waited = 0;
    int lat = 0;
    while (!in_ready && waited < 60) begin tick(); waited++; end
    check("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    height   = 8'(h);
    weight   = 7'(w);
    tick();
    in_valid = 1'b0;
    height   = 8'($urandom);
    weight   = 7'($urandom);
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("latency", lat, (ee != 0) ? 0 : 23);
    check("bmi", 32'(bmi), eb);
    check("speed_level", 32'(speed_level), el);
    check("err", 32'(err), ee);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_bmi", 32'(bmi), eb);
      check("hold_level", 32'(speed_level), el);
      check("hold_err", 32'(err), ee);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consumed_out_valid", 32'(out_valid), 0);
    check("consumed_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int eb, el, ee, h, w, ov_seen;
    int acc[$];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    height    = '0;
    weight    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_bmi", 32'(bmi), 0);
    check("rst_level", 32'(speed_level), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 32'(in_ready), 1);

`ifdef BMI_ROUND_EN
    run_sample(175, 70, 23, 6, 0, 0);
    run_sample(200, 50, 13, 10, 0, 1);
`else
    run_sample(175, 70, 22, 6, 0, 0);
    run_sample(200, 50, 12, 10, 0, 1);
`endif
    run_sample(150, 45, 20, 7, 0, 10);
    run_sample(120, 120, 63, 1, 0, 0);
    run_sample(50, 70, 0, 0, 1, 2);
    run_sample(175, 0, 0, 0, 1, 0);
    run_sample(99, 127, 0, 0, 1, 0);
    run_sample(100, 1, 1, 10, 0, 0);

    for (int k = 0; k < 25; k++) begin
      h = int'($urandom_range(60, 255));
      w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
      model(h, w, eb, el, ee);
      run_sample(h, w, eb, el, ee, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a computation drops the sample.
    in_valid = 1'b1; height = 8'd175; weight = 7'd70;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_bmi", 32'(bmi), 0);
    check("midrst_level", 32'(speed_level), 0);
    check("midrst_err", 32'(err), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("midrst_no_output", ov_seen, 0);

    // Back-to-back with in_valid held and out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    height    = 8'd175;
    weight    = 7'd70;
    for (int c = 0; c < 130; c++) begin
      if (in_ready) acc.push_back(c);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accept_count", acc.size(), 6);
    for (int i = 1; i < acc.size(); i++) check("b2b_interval", acc[i] - acc[i-1], 25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
